// File: rtl/mul_share_ctrl.sv
// rtl/mul_share_ctrl.sv - two-requester round-robin sequencer for a shared multi-cycle multiplier
//
// Purpose: arbitrates two requesters onto one multiplication_block, pulses its
// start for one cycle, holds the operands stable until it finishes, and returns
// the product with requester ID and tag on a valid/ready response port.
//
// Ports:
//   clk, reset_i   clock (rising edge), asynchronous active-high reset
//   req0_*/req1_*  valid/ready operation request: operands a/b and tag
//   mul_*          start pulse, latched operands, done level, product
//   rsp_*          valid/ready response: product, requester ID, tag, error
//
// Build option: define MUL_TIMEOUT_EN to enable the BUSY watchdog. After TIMEOUT
// BUSY cycles without a qualified done, the operation ends with rsp_err_o = 1
// and a zero product. Without it, BUSY waits indefinitely and rsp_err_o is 0.
module mul_share_ctrl #(
  parameter int WIDTH   = 64,
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 80
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,
  input  logic [TAG_W-1:0] req0_tag_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,
  input  logic [TAG_W-1:0] req1_tag_i,
  output logic             mul_start_o,
  output logic [WIDTH-1:0] mul_multiplier_o,
  output logic [WIDTH-1:0] mul_multiplicand_o,
  input  logic             mul_done_i,
  input  logic [WIDTH-1:0] mul_product_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_product_o,
  output logic             rsp_id_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             rsp_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_RESP} state_t;

  state_t           r_state;
  logic             r_last_grant;
  logic             r_busy_first;
  logic             r_mul_start;
  logic             r_rsp_valid;
  logic             r_id;
  logic [TAG_W-1:0] r_tag;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_product;

  logic w_grant_valid;
  logic w_grant_id;
  logic w_accept;
  logic w_done_q;

`ifdef MUL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_rsp_err;
  assign rsp_err_o = r_rsp_err;
`else
  // TIMEOUT only matters to the watchdog build; referenced here so it is not dangling.
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
  assign rsp_err_o = 1'b0;
`endif

  // Round-robin: on a tie the requester that did not win last time is granted.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_id    = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      w_grant_valid = 1'b1;
      w_grant_id    = ~r_last_grant;
    end else if (req0_valid_i) begin
      w_grant_valid = 1'b1;
      w_grant_id    = 1'b0;
    end else if (req1_valid_i) begin
      w_grant_valid = 1'b1;
      w_grant_id    = 1'b1;
    end
  end

  // Ready is gated by reset so every output reads 0 while reset is held.
  assign w_accept     = (r_state == S_IDLE) && w_grant_valid && !reset_i;
  assign req0_ready_o = w_accept && !w_grant_id;
  assign req1_ready_o = w_accept &&  w_grant_id;

  // A sticky done left over from the previous operation is masked in the first BUSY cycle.
  assign w_done_q = (r_state == S_BUSY) && !r_busy_first && mul_done_i;

  assign mul_start_o        = r_mul_start;
  assign mul_multiplier_o   = r_a;
  assign mul_multiplicand_o = r_b;
  assign rsp_valid_o        = r_rsp_valid;
  assign rsp_product_o      = r_product;
  assign rsp_id_o           = r_id;
  assign rsp_tag_o          = r_tag;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_busy_first <= 1'b0;
      r_mul_start  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_id         <= 1'b0;
      r_tag        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_product    <= '0;
`ifdef MUL_TIMEOUT_EN
      r_cnt        <= '0;
      r_rsp_err    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a          <= w_grant_id ? req1_a_i   : req0_a_i;
            r_b          <= w_grant_id ? req1_b_i   : req0_b_i;
            r_tag        <= w_grant_id ? req1_tag_i : req0_tag_i;
            r_id         <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_mul_start  <= 1'b1;
            r_state      <= S_START;
          end
        end
        S_START: begin
          r_mul_start  <= 1'b0;
          r_busy_first <= 1'b1;
`ifdef MUL_TIMEOUT_EN
          r_cnt        <= '0;
`endif
          r_state      <= S_BUSY;
        end
        S_BUSY: begin
          r_busy_first <= 1'b0;
          if (w_done_q) begin
            r_product   <= mul_product_i;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
`ifdef MUL_TIMEOUT_EN
          // r_cnt counts completed BUSY cycles, so this fires on the TIMEOUT-th one.
          else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_product   <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
`ifdef MUL_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
`endif
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb/tb_mul_share_ctrl.sv - randomized self-checking bench for mul_share_ctrl
module tb_mul_share_ctrl;
  localparam int WIDTH   = 64;
  localparam int TAG_W   = 5;
  localparam int TIMEOUT = 80;

  logic             clk = 1'b0;
  logic             reset_i;
  logic             req0_valid_i, req0_ready_o;
  logic [WIDTH-1:0] req0_a_i, req0_b_i;
  logic [TAG_W-1:0] req0_tag_i;
  logic             req1_valid_i, req1_ready_o;
  logic [WIDTH-1:0] req1_a_i, req1_b_i;
  logic [TAG_W-1:0] req1_tag_i;
  logic             mul_start_o;
  logic [WIDTH-1:0] mul_multiplier_o, mul_multiplicand_o;
  logic             mul_done_i;
  logic [WIDTH-1:0] mul_product_i;
  logic             rsp_valid_o, rsp_ready_i;
  logic [WIDTH-1:0] rsp_product_o;
  logic             rsp_id_o;
  logic [TAG_W-1:0] rsp_tag_o;
  logic             rsp_err_o;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int mdl_lat = 4;
  bit mdl_never = 1'b0;
  int m_last = 1;

  mul_share_ctrl #(.WIDTH(WIDTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_i(reset_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_a_i(req0_a_i), .req0_b_i(req0_b_i), .req0_tag_i(req0_tag_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_a_i(req1_a_i), .req1_b_i(req1_b_i), .req1_tag_i(req1_tag_i),
    .mul_start_o(mul_start_o), .mul_multiplier_o(mul_multiplier_o),
    .mul_multiplicand_o(mul_multiplicand_o), .mul_done_i(mul_done_i),
    .mul_product_i(mul_product_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_product_o(rsp_product_o), .rsp_id_o(rsp_id_o),
    .rsp_tag_o(rsp_tag_o), .rsp_err_o(rsp_err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: done is sticky, staying high (with the old product) through
  // the cycle after start is seen; the new product arrives mdl_lat edges after start.
  int               m_cnt = 0;
  bit               m_run = 1'b0;
  logic [WIDTH-1:0] m_a, m_b;
  always @(posedge clk) begin
    if (reset_i) begin
      mul_done_i <= 1'b0; mul_product_i <= '0; m_run <= 1'b0; m_cnt <= 0;
    end else if (mul_start_o) begin
      m_run <= 1'b1; m_cnt <= mdl_lat; m_a <= mul_multiplier_o; m_b <= mul_multiplicand_o;
    end else if (m_run) begin
      if (m_cnt <= 1 && !mdl_never) begin
        mul_done_i <= 1'b1; mul_product_i <= m_a * m_b; m_run <= 1'b0;
      end else begin
        mul_done_i <= 1'b0;
        if (m_cnt > 1) m_cnt <= m_cnt - 1;
      end
    end
  end

  function automatic int exp_grant(input bit v0, input bit v1);
    if (v0 && v1) return (m_last == 0) ? 1 : 0;
    return v0 ? 0 : 1;
  endfunction

  function automatic logic [WIDTH-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic do_reset();
    reset_i = 1'b1; req0_valid_i = 1'b0; req1_valid_i = 1'b0; rsp_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1; reset_i = 1'b0; m_last = 1;
  endtask

  // Drives one operation and observes it; comparisons are made by the callers.
  task automatic run_op(
    input bit v0, input bit v1,
    input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0, input logic [TAG_W-1:0] t0,
    input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1, input logic [TAG_W-1:0] t1,
    input int stall,
    output int gid, output int t_hs, output bit start_ok, output int t_rsp,
    output logic [WIDTH-1:0] prod, output logic id, output logic [TAG_W-1:0] tag,
    output logic err, output bit leak, output bit unstable, output bit to);
    logic [WIDTH-1:0] acc_a, acc_b;
    bit found;
    gid = -1; t_hs = -1; start_ok = 1'b0; t_rsp = -1; prod = '0; id = 1'b0; tag = '0;
    err = 1'b0; leak = 1'b0; unstable = 1'b0; to = 1'b0;
    req0_valid_i = v0; req0_a_i = a0; req0_b_i = b0; req0_tag_i = t0;
    req1_valid_i = v1; req1_a_i = a1; req1_b_i = b1; req1_tag_i = t1;
    rsp_ready_i = (stall == 0);
    found = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      #1;
      if (req0_ready_o || req1_ready_o) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!found) to = 1'b1;
    else begin
      leak = req0_ready_o && req1_ready_o;
      gid = req1_ready_o ? 1 : 0;
      t_hs = cyc;
      acc_a = (gid == 1) ? a1 : a0;
      acc_b = (gid == 1) ? b1 : b0;
      @(posedge clk); #1;
      if (gid == 1) req1_valid_i = 1'b0; else req0_valid_i = 1'b0;
      start_ok = (mul_start_o === 1'b1);
      if (mul_multiplier_o !== acc_a || mul_multiplicand_o !== acc_b) unstable = 1'b1;
      @(posedge clk); #1;
      found = 1'b0;
      for (int n = 0; n < 400 && !found; n++) begin
        if (req0_ready_o || req1_ready_o) leak = 1'b1;
        if (mul_multiplier_o !== acc_a || mul_multiplicand_o !== acc_b) unstable = 1'b1;
        if (mul_start_o !== 1'b0) start_ok = 1'b0;
        if (rsp_valid_o === 1'b1) found = 1'b1;
        else begin @(posedge clk); #1; end
      end
      if (!found) to = 1'b1;
      else begin
        t_rsp = cyc; prod = rsp_product_o; id = rsp_id_o; tag = rsp_tag_o; err = rsp_err_o;
        for (int s = 0; s < stall; s++) begin
          @(posedge clk); #1;
          if (req0_ready_o || req1_ready_o) leak = 1'b1;
          if (rsp_valid_o !== 1'b1 || rsp_product_o !== prod || rsp_id_o !== id ||
              rsp_tag_o !== tag || rsp_err_o !== err ||
              mul_multiplier_o !== acc_a || mul_multiplicand_o !== acc_b) unstable = 1'b1;
        end
        rsp_ready_i = 1'b1; #1;
        if (req0_ready_o || req1_ready_o) leak = 1'b1;
        if (rsp_valid_o !== 1'b1) unstable = 1'b1;
        @(posedge clk); #1;
        rsp_ready_i = 1'b0;
      end
    end
    if (to) begin req0_valid_i = 1'b0; req1_valid_i = 1'b0; rsp_ready_i = 1'b0; end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    req0_valid_i = 1'b1; req0_a_i = rnd64(); req0_b_i = rnd64(); req0_tag_i = 5'd3;
    req1_valid_i = 1'b1; req1_a_i = rnd64(); req1_b_i = rnd64(); req1_tag_i = 5'd4;
    rsp_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (req0_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready0 got %b want 0", req0_ready_o); end
    n_vec++; if (req1_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready1 got %b want 0", req1_ready_o); end
    n_vec++; if (mul_start_o !== 1'b0) begin n_err++; $display("FAIL reset_start got %b want 0", mul_start_o); end
    n_vec++; if (rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid_o); end
    n_vec++; if (rsp_product_o !== '0) begin n_err++; $display("FAIL reset_product got %0h want 0", rsp_product_o); end
    n_vec++; if ({rsp_id_o, rsp_tag_o, rsp_err_o} !== '0) begin n_err++; $display("FAIL reset_id_tag_err got %b want 0", {rsp_id_o, rsp_tag_o, rsp_err_o}); end
    n_vec++; if ({mul_multiplier_o, mul_multiplicand_o} !== '0) begin n_err++; $display("FAIL reset_operands got %0h want 0", {mul_multiplier_o, mul_multiplicand_o}); end
    reset_i = 1'b0; req0_valid_i = 1'b0; req1_valid_i = 1'b0; rsp_ready_i = 1'b0; m_last = 1;
  endtask

  task automatic test_single();
    int gid, t_hs, t_rsp; bit st, lk, un, to;
    logic [WIDTH-1:0] pr; logic id, er; logic [TAG_W-1:0] tg;
    mdl_lat = 33;
    run_op(1'b1, 1'b0, 64'd3, 64'd7, 5'd5, '0, '0, '0, 0, gid, t_hs, st, t_rsp, pr, id, tg, er, lk, un, to);
    m_last = 0;
    n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL single_timeout got %b want 0", to); end
    n_vec++; if (gid !== 0) begin n_err++; $display("FAIL single_grant got %0d want 0", gid); end
    n_vec++; if (st !== 1'b1) begin n_err++; $display("FAIL single_start_pulse got %b want 1", st); end
    n_vec++; if (t_rsp !== t_hs + 3 + 33) begin n_err++; $display("FAIL single_latency got %0d want %0d", t_rsp - t_hs, 36); end
    n_vec++; if (pr !== 64'd21) begin n_err++; $display("FAIL single_product got %0h want 15", pr); end
    n_vec++; if (id !== 1'b0 || tg !== 5'd5) begin n_err++; $display("FAIL single_id_tag got %b/%0d want 0/5", id, tg); end
    n_vec++; if (er !== 1'b0 || lk !== 1'b0 || un !== 1'b0) begin n_err++; $display("FAIL single_err_leak_stable got %b%b%b want 000", er, lk, un); end
    n_vec++; if (rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL single_rsp_drop got %b want 0", rsp_valid_o); end
  endtask

  task automatic test_round_robin();
    int gid, t_hs, t_rsp; bit st, lk, un, to;
    logic [WIDTH-1:0] pr; logic id, er; logic [TAG_W-1:0] tg;
    logic [WIDTH-1:0] ra [2]; logic [WIDTH-1:0] rb [2]; logic [TAG_W-1:0] rt [2];
    do_reset();
    for (int r = 0; r < 2; r++) begin ra[r] = rnd64(); rb[r] = rnd64(); rt[r] = TAG_W'($urandom_range(0, 31)); end
    for (int i = 0; i < 5; i++) begin
      int eg;
      eg = i % 2;
      mdl_lat = 3 + i;
      run_op(1'b1, (i < 4), ra[0], rb[0], rt[0], ra[1], rb[1], rt[1], 0,
             gid, t_hs, st, t_rsp, pr, id, tg, er, lk, un, to);
      n_vec++; if (gid !== eg) begin n_err++; $display("FAIL rr_grant%0d got %0d want %0d", i, gid, eg); end
      n_vec++; if (pr !== ra[eg] * rb[eg]) begin n_err++; $display("FAIL rr_product%0d got %0h want %0h", i, pr, ra[eg] * rb[eg]); end
      n_vec++; if (id !== eg[0] || tg !== rt[eg]) begin n_err++; $display("FAIL rr_id_tag%0d got %b/%0d want %0d/%0d", i, id, tg, eg, rt[eg]); end
      n_vec++; if (lk !== 1'b0 || un !== 1'b0 || to !== 1'b0 || st !== 1'b1) begin n_err++; $display("FAIL rr_proto%0d got %b%b%b%b want 0001", i, lk, un, to, st); end
      m_last = eg;
      ra[eg] = rnd64(); rb[eg] = rnd64(); rt[eg] = TAG_W'($urandom_range(0, 31));
    end
  endtask

  task automatic test_stall();
    int gid, t_hs, t_rsp, eg; bit st, lk, un, to;
    logic [WIDTH-1:0] pr, exp; logic id, er; logic [TAG_W-1:0] tg;
    logic [WIDTH-1:0] neg2;
    neg2 = -64'sd2;
    exp = 64'hFFFF_FFFF_FFFF_FFEE;
    mdl_lat = 5;
    eg = exp_grant(1'b1, 1'b1);
    run_op(1'b1, 1'b1, neg2, 64'd9, 5'd9, neg2, 64'd9, 5'd10, 10, gid, t_hs, st, t_rsp, pr, id, tg, er, lk, un, to);
    n_vec++; if (gid !== eg) begin n_err++; $display("FAIL stall_grant got %0d want %0d", gid, eg); end
    n_vec++; if (pr !== exp) begin n_err++; $display("FAIL stall_product got %0h want %0h", pr, exp); end
    n_vec++; if (un !== 1'b0) begin n_err++; $display("FAIL stall_stable got %b want 0", un); end
    n_vec++; if (lk !== 1'b0) begin n_err++; $display("FAIL stall_ready_leak got %b want 0", lk); end
    n_vec++; if (tg !== ((eg == 1) ? 5'd10 : 5'd9)) begin n_err++; $display("FAIL stall_tag got %0d want %0d", tg, (eg == 1) ? 10 : 9); end
    m_last = eg;
    run_op((eg == 1), (eg == 0), neg2, 64'd9, 5'd9, neg2, 64'd9, 5'd10, 0, gid, t_hs, st, t_rsp, pr, id, tg, er, lk, un, to);
    n_vec++; if (gid !== 1 - eg || pr !== exp) begin n_err++; $display("FAIL stall_drain got %0d/%0h want %0d/%0h", gid, pr, 1 - eg, exp); end
    m_last = 1 - eg;
  endtask

  task automatic test_sticky();
    int gid, t_hs, t_rsp; bit st, lk, un, to;
    logic [WIDTH-1:0] pr, a1, b1, a2, b2; logic id, er; logic [TAG_W-1:0] tg;
    a1 = rnd64(); b1 = rnd64(); a2 = a1 + 64'd1; b2 = b1 ^ 64'h5A;
    mdl_lat = 6;
    run_op(1'b1, 1'b0, a1, b1, 5'd1, '0, '0, '0, 0, gid, t_hs, st, t_rsp, pr, id, tg, er, lk, un, to);
    m_last = 0;
    run_op(1'b1, 1'b0, a2, b2, 5'd2, '0, '0, '0, 0, gid, t_hs, st, t_rsp, pr, id, tg, er, lk, un, to);
    n_vec++; if (pr !== a2 * b2) begin n_err++; $display("FAIL sticky_product got %0h want %0h", pr, a2 * b2); end
    n_vec++; if (t_rsp !== t_hs + 3 + 6) begin n_err++; $display("FAIL sticky_latency got %0d want 9", t_rsp - t_hs); end
    n_vec++; if (tg !== 5'd2) begin n_err++; $display("FAIL sticky_tag got %0d want 2", tg); end
  endtask

  task automatic test_reset_busy();
    int gid, t_hs, t_rsp; bit st, lk, un, to;
    logic [WIDTH-1:0] pr, a, b; logic id, er; logic [TAG_W-1:0] tg;
    mdl_lat = 30;
    req0_valid_i = 1'b1; req0_a_i = 64'd5; req0_b_i = 64'd6; req0_tag_i = 5'd3;
    req1_valid_i = 1'b0; rsp_ready_i = 1'b1;
    #1;
    n_vec++; if (req0_ready_o !== 1'b1) begin n_err++; $display("FAIL rstbusy_accept got %b want 1", req0_ready_o); end
    @(posedge clk); #1; req0_valid_i = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    a = rnd64(); b = rnd64();
    #1; reset_i = 1'b1;
    req1_valid_i = 1'b1; req1_a_i = a; req1_b_i = b; req1_tag_i = 5'd17;
    #1;
    n_vec++; if ({mul_start_o, rsp_valid_o, req0_ready_o, req1_ready_o, rsp_err_o} !== '0) begin n_err++; $display("FAIL rstbusy_ctrl got %b want 0", {mul_start_o, rsp_valid_o, req0_ready_o, req1_ready_o, rsp_err_o}); end
    n_vec++; if ({mul_multiplier_o, mul_multiplicand_o, rsp_product_o} !== '0) begin n_err++; $display("FAIL rstbusy_data got %0h want 0", {mul_multiplier_o, mul_multiplicand_o, rsp_product_o}); end
    n_vec++; if ({rsp_id_o, rsp_tag_o} !== '0) begin n_err++; $display("FAIL rstbusy_id_tag got %0h want 0", {rsp_id_o, rsp_tag_o}); end
    @(posedge clk); #1;
    reset_i = 1'b0; m_last = 1;
    mdl_lat = 8;
    run_op(1'b0, 1'b1, '0, '0, '0, a, b, 5'd17, 0, gid, t_hs, st, t_rsp, pr, id, tg, er, lk, un, to);
    n_vec++; if (gid !== 1 || id !== 1'b1 || tg !== 5'd17) begin n_err++; $display("FAIL rstbusy_next_id got %0d/%b/%0d want 1/1/17", gid, id, tg); end
    n_vec++; if (pr !== a * b || t_rsp !== t_hs + 3 + 8) begin n_err++; $display("FAIL rstbusy_next_prod got %0h lat %0d want %0h lat 11", pr, t_rsp - t_hs, a * b); end
    m_last = 1;
  endtask

  task automatic test_random();
    int gid, t_hs, t_rsp, eg, lat, stall; bit st, lk, un, to;
    logic [WIDTH-1:0] pr; logic id, er; logic [TAG_W-1:0] tg;
    bit pend [2];
    logic [WIDTH-1:0] ra [2]; logic [WIDTH-1:0] rb [2]; logic [TAG_W-1:0] rt [2];
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i >= 12 && !pend[0] && !pend[1]) break;
      if (i < 12) begin
        for (int r = 0; r < 2; r++)
          if (!pend[r] && $urandom_range(0, 1) == 1) begin
            pend[r] = 1'b1; ra[r] = rnd64(); rb[r] = rnd64(); rt[r] = TAG_W'($urandom_range(0, 31));
          end
        if (!pend[0] && !pend[1]) begin
          eg = $urandom_range(0, 1);
          pend[eg] = 1'b1; ra[eg] = rnd64(); rb[eg] = rnd64(); rt[eg] = TAG_W'($urandom_range(0, 31));
        end
      end
      lat = $urandom_range(2, 12);
      stall = $urandom_range(0, 3);
      mdl_lat = lat;
      eg = exp_grant(pend[0], pend[1]);
      run_op(pend[0], pend[1], ra[0], rb[0], rt[0], ra[1], rb[1], rt[1], stall,
             gid, t_hs, st, t_rsp, pr, id, tg, er, lk, un, to);
      n_vec++; if (gid !== eg) begin n_err++; $display("FAIL rnd_grant%0d got %0d want %0d", i, gid, eg); end
      n_vec++; if (pr !== ra[eg] * rb[eg] || id !== eg[0] || tg !== rt[eg]) begin n_err++; $display("FAIL rnd_rsp%0d got %0h/%b/%0d want %0h/%0d/%0d", i, pr, id, tg, ra[eg] * rb[eg], eg, rt[eg]); end
      n_vec++; if (t_rsp !== t_hs + 3 + lat) begin n_err++; $display("FAIL rnd_latency%0d got %0d want %0d", i, t_rsp - t_hs, 3 + lat); end
      n_vec++; if ({lk, un, to, er, st} !== 5'b00001) begin n_err++; $display("FAIL rnd_proto%0d got %b want 00001", i, {lk, un, to, er, st}); end
      m_last = eg;
      pend[eg] = 1'b0;
    end
  endtask

`ifdef MUL_TIMEOUT_EN
  task automatic test_timeout();
    int gid, t_hs, t_rsp; bit st, lk, un, to;
    logic [WIDTH-1:0] pr; logic id, er; logic [TAG_W-1:0] tg;
    mdl_never = 1'b1;
    run_op(1'b1, 1'b0, 64'd11, 64'd13, 5'd7, '0, '0, '0, 2, gid, t_hs, st, t_rsp, pr, id, tg, er, lk, un, to);
    mdl_never = 1'b0;
    m_last = 0;
    n_vec++; if (t_rsp !== t_hs + 2 + TIMEOUT) begin n_err++; $display("FAIL tmo_latency got %0d want %0d", t_rsp - t_hs, 2 + TIMEOUT); end
    n_vec++; if (er !== 1'b1 || pr !== '0) begin n_err++; $display("FAIL tmo_err_prod got %b/%0h want 1/0", er, pr); end
    n_vec++; if (rsp_err_o !== 1'b0) begin n_err++; $display("FAIL tmo_err_clear got %b want 0", rsp_err_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_sticky();
    test_reset_busy();
    test_random();
`ifdef MUL_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "bench watchdog expired");
  end

endmodule
